// File: rtl/three_eight_decoder_seq_pkg.sv
// Shared types and constants for the registered 3-to-8 decoder.
// State encoding is fixed so that state values seen in waveforms stay stable.
package three_eight_decoder_seq_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_e;

    // Index of the eighth code in a scan; finishing it ends the scan.
    localparam logic [CODE_W-1:0] LAST_STEP = 3'd7;

endpackage

// File: rtl/three_eight_decoder_seq_onehot_dec3.sv
// Pure combinational 3-to-8 one-hot decode; exactly one output bit is always set.
// No latency, no flow control.
module onehot_dec3
    import three_eight_decoder_seq_pkg::*;
(
    input  logic [CODE_W-1:0]   code_i,
    output logic [ONEHOT_W-1:0] onehot_o
);

    always_comb begin
        onehot_o         = '0;
        onehot_o[code_i] = 1'b1;
    end

endmodule

// File: rtl/three_eight_decoder_seq.sv
// Registered 3-to-8 decoder: direct hold of an accepted code, or a self-timed
// sweep through all eight lines, each held for DWELL cycles, ending with a done pulse.
module three_eight_decoder_seq
    import three_eight_decoder_seq_pkg::*;
#(
    parameter int unsigned DWELL = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CODE_W-1:0]   a,
    input  logic                mode,
    input  logic                a_valid,
    output logic                a_ready,
    output logic [ONEHOT_W-1:0] y,
    output logic                y_valid,
    output logic                done
);

    localparam logic [7:0] DWELL_RELOAD = 8'(DWELL - 1);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [7:0]          dwell_q, dwell_d;
    logic [CODE_W-1:0]   step_q, step_d;
    logic [ONEHOT_W-1:0] y_q, y_d;
    logic                y_valid_q, y_valid_d;
    logic                done_q, done_d;
    logic                accept;
    logic [ONEHOT_W-1:0] code_onehot;

    assign a_ready = !rst && en && (state_q != ST_SCAN);
    assign accept  = a_valid && a_ready;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        dwell_d = dwell_q;
        step_d  = step_q;
        done_d  = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        code_d  = a;
                        state_d = mode ? ST_SCAN : ST_HOLD;
                        dwell_d = DWELL_RELOAD;
                        step_d  = '0;
                    end
                end
                ST_SCAN: begin
                    if (dwell_q != 8'd0) begin
                        dwell_d = dwell_q - 8'd1;
                    end else if (step_q == LAST_STEP) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // 3-bit add wraps 7 back to 0
                        code_d  = code_q + 3'd1;
                        step_d  = step_q + 3'd1;
                        dwell_d = DWELL_RELOAD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Decode the next code so y lands on the same edge as the state change.
    onehot_dec3 u_dec (
        .code_i   (code_d),
        .onehot_o (code_onehot)
    );

    always_comb begin
        y_valid_d = (state_d != ST_IDLE);
        y_d       = y_valid_d ? code_onehot : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            code_q    <= '0;
            dwell_q   <= '0;
            step_q    <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            dwell_q   <= dwell_d;
            step_q    <= step_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            done_q    <= done_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign done    = done_q;

endmodule

// File: tb/tb_three_eight_decoder_seq.sv
// Directed bench for three_eight_decoder_seq: a vector table for reset and direct
// decode, plus hand-written sequences for scan wrap, abort, hold-to-scan and mid-scan reset.
module tb_three_eight_decoder_seq;

    logic       clk = 1'b0;
    logic       rst, en, mode, a_valid;
    logic [2:0] a;

    logic       rdy2, yv2, done2;
    logic [7:0] y2;
    logic       rdy4, yv4, done4;
    logic [7:0] y4;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    three_eight_decoder_seq #(.DWELL(2)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .a(a), .mode(mode), .a_valid(a_valid),
        .a_ready(rdy2), .y(y2), .y_valid(yv2), .done(done2)
    );

    three_eight_decoder_seq #(.DWELL(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .a(a), .mode(mode), .a_valid(a_valid),
        .a_ready(rdy4), .y(y4), .y_valid(yv4), .done(done4)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] a;
        logic       mode;
        logic       av;
        logic       rdy;   // a_ready while these inputs are applied
        logic [7:0] y;     // outputs after the edge that samples them
        logic       yv;
        logic       done;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mkv(input logic r, input logic e, input logic [2:0] ai,
                                 input logic m, input logic av, input logic rdy,
                                 input logic [7:0] yy, input logic yv, input logic d);
        vec_t v;
        v.rst = r; v.en = e; v.a = ai; v.mode = m; v.av = av;
        v.rdy = rdy; v.y = yy; v.yv = yv; v.done = d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic r, input logic e, input logic [2:0] ai,
                       input logic m, input logic av);
        rst = r; en = e; a = ai; mode = m; a_valid = av;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drv(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        to_edge();
        drv(1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] one;
        one = 8'h01;

        tbl[0]  = mkv(1, 1, 3'd5, 0, 1, 0, 8'h00, 0, 0);
        tbl[1]  = mkv(1, 1, 3'd5, 0, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++)
            tbl[2+i] = mkv(0, 1, 3'(i), 0, 1, 1, one << i, 1, 0);
        tbl[10] = mkv(0, 1, 3'd3, 0, 0, 1, 8'h80, 1, 0);
        tbl[11] = mkv(0, 0, 3'd3, 0, 1, 0, 8'h00, 0, 0);
        tbl[12] = mkv(0, 1, 3'd2, 0, 0, 1, 8'h00, 0, 0);

        // Table: reset, direct sweep, hold, en-low drop, idle without accept
        for (int i = 0; i < 13; i++) begin
            drv(tbl[i].rst, tbl[i].en, tbl[i].a, tbl[i].mode, tbl[i].av);
            to_neg();
            chk($sformatf("tbl%0d_rdy2", i), 8'(rdy2), 8'(tbl[i].rdy));
            chk($sformatf("tbl%0d_rdy4", i), 8'(rdy4), 8'(tbl[i].rdy));
            to_edge();
            chk($sformatf("tbl%0d_y2", i), y2, tbl[i].y);
            chk($sformatf("tbl%0d_y4", i), y4, tbl[i].y);
            chk($sformatf("tbl%0d_yv2", i), 8'(yv2), 8'(tbl[i].yv));
            chk($sformatf("tbl%0d_done2", i), 8'(done2), 8'(tbl[i].done));
        end

        // Scan with wrap, DWELL=2, from code 6; inputs held valid but must be ignored
        do_reset();
        drv(0, 1, 3'd6, 1, 1);
        to_neg();
        chk("scan_accept_rdy", 8'(rdy2), 8'h01);
        to_edge();
        drv(0, 1, 3'd0, 0, 1);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                to_neg();
                chk($sformatf("scan_rdy_k%0d", k), 8'(rdy2), 8'h00);
                to_edge();
            end
            chk($sformatf("scan_y_k%0d", k), y2, one << ((6 + k/2) % 8));
            chk($sformatf("scan_yv_k%0d", k), 8'(yv2), 8'h01);
            chk($sformatf("scan_done_k%0d", k), 8'(done2), 8'h00);
        end
        to_neg();
        chk("scan_last_rdy", 8'(rdy2), 8'h00);
        to_edge();
        chk("scan_end_y", y2, 8'h00);
        chk("scan_end_yv", 8'(yv2), 8'h00);
        chk("scan_end_done", 8'(done2), 8'h01);
        drv(0, 1, 3'd0, 0, 0);
        to_neg();
        chk("scan_done_cycle_rdy", 8'(rdy2), 8'h01);
        to_edge();
        chk("scan_done_pulse_len", 8'(done2), 8'h00);

        // Abort, DWELL=4, scan from 0, en dropped in scan cycle 5
        do_reset();
        drv(0, 1, 3'd0, 1, 1);
        to_edge();
        drv(0, 1, 3'd0, 0, 0);
        for (int k = 1; k < 5; k++) to_edge();
        chk("abort_pre_y", y4, 8'h02);
        drv(0, 0, 3'd0, 0, 0);
        to_edge();
        chk("abort_y", y4, 8'h00);
        chk("abort_yv", 8'(yv4), 8'h00);
        begin
            int seen_done;
            seen_done = 0;
            for (int k = 0; k < 40; k++) begin
                to_edge();
                if (done4 !== 1'b0 || yv4 !== 1'b0) seen_done++;
            end
            chk("abort_no_done", 8'(seen_done), 8'h00);
        end
        drv(0, 1, 3'd2, 0, 1);
        to_edge();
        chk("abort_recover_y", y4, 8'h04);
        chk("abort_recover_yv", 8'(yv4), 8'h01);

        // HOLD to SCAN with no zero gap, DWELL=2
        do_reset();
        drv(0, 1, 3'd5, 0, 1);
        to_edge();
        chk("h2s_hold_y", y2, 8'h20);
        drv(0, 1, 3'd1, 1, 1);
        to_neg();
        chk("h2s_rdy", 8'(rdy2), 8'h01);
        to_edge();
        chk("h2s_first_y", y2, 8'h02);
        drv(0, 1, 3'd0, 0, 0);
        begin
            int done_at, gaps;
            done_at = -1;
            gaps = 0;
            for (int k = 1; k <= 20 && done_at < 0; k++) begin
                to_edge();
                if (done2 === 1'b1) done_at = k;
                else if (yv2 !== 1'b1) gaps++;
            end
            chk("h2s_done_edge", 8'(done_at), 8'd16);
            chk("h2s_gaps", 8'(gaps), 8'h00);
        end

        // Reset during the third scan step, DWELL=2 from code 3
        do_reset();
        drv(0, 1, 3'd3, 1, 1);
        to_edge();
        drv(0, 1, 3'd0, 0, 0);
        for (int k = 1; k < 5; k++) to_edge();
        chk("rstmid_pre_y", y2, 8'h20);
        drv(1, 1, 3'd7, 0, 1);
        to_neg();
        chk("rstmid_rdy", 8'(rdy2), 8'h00);
        to_edge();
        chk("rstmid_y", y2, 8'h00);
        chk("rstmid_yv", 8'(yv2), 8'h00);
        chk("rstmid_done", 8'(done2), 8'h00);
        drv(0, 1, 3'd7, 0, 1);
        to_edge();
        chk("rstmid_after_y", y2, 8'h80);
        chk("rstmid_after_yv", 8'(yv2), 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
